// File: rtl/axis_frame_gen_pkg.sv
// Shared types and helpers for the AXI4-Stream test-frame generator.
// State encoding, payload modes, LFSR constants and last-beat keep mask.
package axis_frame_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_INC     = 2'd0;
    localparam logic [1:0] MODE_LFSR    = 2'd1;
    localparam logic [1:0] MODE_FILL    = 2'd2;
    localparam logic [1:0] MODE_INC_ALT = 2'd3;

    localparam logic [31:0] LFSR_SEED = 32'hFFFF_FFFF;
    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam int MAX_KEEP_W = 64;

    function automatic logic [MAX_KEEP_W-1:0] keep_from_len(
        input int unsigned len,
        input int unsigned keep_w
    );
        int unsigned rem;
        logic [MAX_KEEP_W-1:0] k;
        rem = len % keep_w;
        if (rem == 0) rem = keep_w;
        k = '0;
        for (int i = 0; i < MAX_KEEP_W; i++) begin
            if (i < int'(rem)) k[i] = 1'b1;
        end
        return k;
    endfunction

endpackage

// File: rtl/axis_frame_gen_lfsr.sv
// 32-bit Galois LFSR with step enable; o_next exposes the
// successor so a beat loaded on the stepping edge sees the new value.
module axis_frame_gen_lfsr
    import axis_frame_gen_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_step,
    output logic [31:0] o_state,
    output logic [31:0] o_next
);

    assign o_next = {1'b0, o_state[31:1]} ^ (o_state[0] ? LFSR_TAPS : 32'h0);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_state <= LFSR_SEED;
        end else if (i_step) begin
            o_state <= o_next;
        end
    end

endmodule

// File: rtl/axis_frame_generator.sv
// AXI4-Stream test-frame source with backpressure and exact last-beat tkeep.
// Define AXIS_FRAME_GEN_STATS_EN to add frame/byte statistics counters.
module axis_frame_generator
    import axis_frame_gen_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int LEN_W  = 16,
    parameter int IFG_W  = 8,
    parameter int KEEP_W = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [1:0]        i_mode,
    input  logic [7:0]        i_fill,
    input  logic [LEN_W-1:0]  i_frame_len,
    input  logic [IFG_W-1:0]  i_ifg,
    input  logic [15:0]       i_frame_limit,
    input  logic              i_tx_axis_tready,
    output logic              o_tx_axis_tvalid,
    output logic [DATA_W-1:0] o_tx_axis_tdata,
    output logic              o_tx_axis_tlast,
    output logic [KEEP_W-1:0] o_tx_axis_tkeep,
    output logic              o_busy,
    output logic              o_done
`ifdef AXIS_FRAME_GEN_STATS_EN
    ,
    output logic [31:0]       o_frame_cnt,
    output logic [47:0]       o_byte_cnt
`endif
);

    state_t            state;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  beat_q;
    logic [IFG_W-1:0]  ifg_q;
    logic [IFG_W-1:0]  gap_q;
    logic [1:0]        mode_q;
    logic [7:0]        fill_q;
    logic [31:0]       seq_q;
    logic [15:0]       run_q;
    logic [31:0]       lfsr_q;
    logic [31:0]       lfsr_next;

    logic              accept;
    logic              use_cfg;
    logic              load;
    logic              limit_hit;
    logic [LEN_W-1:0]  cfg_len;
    logic [LEN_W-1:0]  ld_len;
    logic [LEN_W-1:0]  ld_last;
    logic [LEN_W-1:0]  ld_idx;
    logic [IFG_W-1:0]  ld_ifg;
    logic [1:0]        ld_mode;
    logic [7:0]        ld_fill;
    logic [31:0]       ld_seq;
    logic [31:0]       ld_lfsr;
    logic [DATA_W-1:0] ld_data;
    logic [KEEP_W-1:0] ld_keep;
    logic              ld_lastb;

    function automatic logic [DATA_W-1:0] beat_data(
        input logic [LEN_W-1:0] idx,
        input logic [1:0]       mode,
        input logic [7:0]       fill,
        input logic [31:0]      seq,
        input logic [31:0]      lfsr
    );
        logic [DATA_W-1:0] d;
        logic [7:0]        base;
        d    = '0;
        base = 8'(32'(idx) * 32'(KEEP_W));
        for (int j = 0; j < KEEP_W; j++) begin
            unique case (1'b1)
                mode == MODE_LFSR: d[j*8 +: 8] = lfsr[(j%4)*8 +: 8];
                mode == MODE_FILL: d[j*8 +: 8] = fill;
                default:           d[j*8 +: 8] = base + 8'(j);
            endcase
        end
        if (idx == '0) d[31:0] = seq;
        return d;
    endfunction

    axis_frame_gen_lfsr u_lfsr (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_step  (accept),
        .o_state (lfsr_q),
        .o_next  (lfsr_next)
    );

    assign cfg_len = (i_frame_len == '0) ? LEN_W'(1) : i_frame_len;

    // A new frame's config comes from the inputs; continuation beats reuse it.
    always_comb begin
        accept  = o_tx_axis_tvalid & i_tx_axis_tready;
        use_cfg = (state != ST_DATA) | o_tx_axis_tlast;
        ld_len  = len_q;
        ld_ifg  = ifg_q;
        ld_mode = mode_q;
        ld_fill = fill_q;
        ld_idx  = beat_q + LEN_W'(1);
        if (use_cfg) begin
            ld_len  = cfg_len;
            ld_ifg  = i_ifg;
            ld_mode = i_mode;
            ld_fill = i_fill;
            ld_idx  = '0;
        end
        ld_last  = LEN_W'((32'(ld_len) - 32'd1) / 32'(KEEP_W));
        ld_lastb = (ld_idx == ld_last);
        ld_keep  = ld_lastb ? KEEP_W'(keep_from_len(32'(ld_len), KEEP_W))
                            : '1;
        ld_seq   = (state == ST_DATA) ? seq_q + 32'd1 : seq_q;
        ld_lfsr  = (state == ST_DATA) ? lfsr_next : lfsr_q;
        ld_data  = beat_data(ld_idx, ld_mode, ld_fill, ld_seq, ld_lfsr);

        limit_hit = (i_frame_limit != '0) &&
                    (run_q + 16'd1 == i_frame_limit);

        unique case (state)
            ST_IDLE: load = i_enable;
            ST_DATA: load = accept & (~o_tx_axis_tlast |
                            (~limit_hit & (ifg_q == '0) & i_enable));
            ST_GAP:  load = (gap_q == IFG_W'(1)) & i_enable;
            default: load = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state            <= ST_IDLE;
            len_q            <= '0;
            beat_q           <= '0;
            ifg_q            <= '0;
            gap_q            <= '0;
            mode_q           <= '0;
            fill_q           <= '0;
            seq_q            <= '0;
            run_q            <= '0;
            o_tx_axis_tvalid <= 1'b0;
            o_tx_axis_tdata  <= '0;
            o_tx_axis_tlast  <= 1'b0;
            o_tx_axis_tkeep  <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
        end else begin
            if (load) begin
                o_tx_axis_tvalid <= 1'b1;
                o_tx_axis_tdata  <= ld_data;
                o_tx_axis_tkeep  <= ld_keep;
                o_tx_axis_tlast  <= ld_lastb;
                beat_q           <= ld_idx;
                len_q            <= ld_len;
                ifg_q            <= ld_ifg;
                mode_q           <= ld_mode;
                fill_q           <= ld_fill;
            end else if (accept) begin
                o_tx_axis_tvalid <= 1'b0;
            end

            unique case (state)
                ST_IDLE: begin
                    if (i_enable) begin
                        state  <= ST_DATA;
                        run_q  <= '0;
                        o_busy <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (accept & o_tx_axis_tlast) begin
                        seq_q <= seq_q + 32'd1;
                        run_q <= run_q + 16'd1;
                        if (limit_hit) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                        end else if (ifg_q != '0) begin
                            state <= ST_GAP;
                            gap_q <= ifg_q;
                        end else if (!i_enable) begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == IFG_W'(1)) begin
                        if (i_enable) begin
                            state <= ST_DATA;
                        end else begin
                            state  <= ST_IDLE;
                            o_busy <= 1'b0;
                        end
                    end else begin
                        gap_q <= gap_q - IFG_W'(1);
                    end
                end
                ST_DONE: begin
                    if (!i_enable) begin
                        state  <= ST_IDLE;
                        o_done <= 1'b0;
                        o_busy <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AXIS_FRAME_GEN_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_frame_cnt <= '0;
            o_byte_cnt  <= '0;
        end else if (accept) begin
            o_byte_cnt <= o_byte_cnt + 48'($countones(o_tx_axis_tkeep));
            if (o_tx_axis_tlast) o_frame_cnt <= o_frame_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axis_frame_generator.sv
// Directed bench for axis_frame_generator (64-bit and 128-bit instances).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_axis_frame_generator;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         en2;
    logic [1:0]   mode;
    logic [7:0]   fill;
    logic [15:0]  len;
    logic [7:0]   ifg;
    logic [15:0]  limit;
    logic         rdy;

    logic         tv;
    logic [63:0]  td;
    logic         tl;
    logic [7:0]   tk;
    logic         busy;
    logic         done;

    logic         tv2;
    logic [127:0] td2;
    logic         tl2;
    logic [15:0]  tk2;
    logic         busy2;
    logic         done2;

`ifdef AXIS_FRAME_GEN_STATS_EN
    logic [31:0]  fcnt;
    logic [47:0]  bcnt;
    logic [31:0]  fcnt2;
    logic [47:0]  bcnt2;
`endif

    int checks = 0;
    int errors = 0;
    int nbeats = 0;
    int nbytes = 0;

    always #5 clk = ~clk;

    axis_frame_generator #(.DATA_W(64)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_enable         (en),
        .i_mode           (mode),
        .i_fill           (fill),
        .i_frame_len      (len),
        .i_ifg            (ifg),
        .i_frame_limit    (limit),
        .i_tx_axis_tready (rdy),
        .o_tx_axis_tvalid (tv),
        .o_tx_axis_tdata  (td),
        .o_tx_axis_tlast  (tl),
        .o_tx_axis_tkeep  (tk),
        .o_busy           (busy),
`ifdef AXIS_FRAME_GEN_STATS_EN
        .o_frame_cnt      (fcnt),
        .o_byte_cnt       (bcnt),
`endif
        .o_done           (done)
    );

    axis_frame_generator #(.DATA_W(128)) dut128 (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_enable         (en2),
        .i_mode           (mode),
        .i_fill           (fill),
        .i_frame_len      (len),
        .i_ifg            (ifg),
        .i_frame_limit    (limit),
        .i_tx_axis_tready (rdy),
        .o_tx_axis_tvalid (tv2),
        .o_tx_axis_tdata  (td2),
        .o_tx_axis_tlast  (tl2),
        .o_tx_axis_tkeep  (tk2),
        .o_busy           (busy2),
`ifdef AXIS_FRAME_GEN_STATS_EN
        .o_frame_cnt      (fcnt2),
        .o_byte_cnt       (bcnt2),
`endif
        .o_done           (done2)
    );

    always @(posedge clk) begin
        if (rst && tv && rdy) begin
            nbeats = nbeats + 1;
            nbytes = nbytes + $countones(tk);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; en2 = 1'b0; mode = 2'd0; fill = 8'h00;
        len = 16'd0; ifg = 8'd0; limit = 16'd0; rdy = 1'b1;
        step(); step();
        chk("rst_tvalid", 128'(tv), 128'(0));
        chk("rst_tdata", 128'(td), 128'(0));
        chk("rst_tkeep", 128'(tk), 128'(0));
        chk("rst_tlast", 128'(tl), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        rst = 1'b1;
        step();

        // basic: len 20, ifg 3, limit 2
        len = 16'd20; ifg = 8'd3; limit = 16'd2; mode = 2'd0; en = 1'b1;
        step();
        chk("f0_valid", 128'(tv), 128'(1));
        chk("f0_b0", 128'(td), 128'(64'h07060504_00000000));
        chk("f0_b0_keep", 128'(tk), 128'(8'hFF));
        chk("f0_b0_last", 128'(tl), 128'(0));
        chk("f0_busy", 128'(busy), 128'(1));
        step();
        chk("f0_b1", 128'(td), 128'(64'h0F0E0D0C_0B0A0908));
        step();
        chk("f0_b2", 128'(td), 128'(64'h17161514_13121110));
        chk("f0_b2_keep", 128'(tk), 128'(8'h0F));
        chk("f0_b2_last", 128'(tl), 128'(1));
        step();
        chk("gap1", 128'(tv), 128'(0));
        step();
        chk("gap2", 128'(tv), 128'(0));
        step();
        chk("gap3", 128'(tv), 128'(0));
        step();
        chk("f1_valid", 128'(tv), 128'(1));
        chk("f1_b0", 128'(td), 128'(64'h07060504_00000001));
        step(); step();
        chk("f1_last", 128'(tl), 128'(1));
        chk("f1_keep", 128'(tk), 128'(8'h0F));
        step();
        chk("done_set", 128'(done), 128'(1));
        chk("done_valid", 128'(tv), 128'(0));
        chk("done_busy", 128'(busy), 128'(1));
        en = 1'b0;
        step();
        chk("done_clr", 128'(done), 128'(0));
        chk("idle_busy", 128'(busy), 128'(0));

        // backpressure: fill mode, stall every other cycle
        nbeats = 0; nbytes = 0;
        len = 16'd20; ifg = 8'd0; limit = 16'd1;
        mode = 2'd2; fill = 8'hA5; en = 1'b1;
        step();
        chk("bp_b0", 128'(td), 128'(64'hA5A5A5A5_00000002));
        rdy = 1'b0;
        step();
        chk("bp_b0_hold", 128'(td), 128'(64'hA5A5A5A5_00000002));
        chk("bp_b0_hold_v", 128'(tv), 128'(1));
        chk("bp_b0_hold_k", 128'(tk), 128'(8'hFF));
        rdy = 1'b1;
        step();
        chk("bp_b1", 128'(td), 128'(64'hA5A5A5A5_A5A5A5A5));
        chk("bp_b1_last", 128'(tl), 128'(0));
        rdy = 1'b0;
        step();
        chk("bp_b1_hold", 128'(td), 128'(64'hA5A5A5A5_A5A5A5A5));
        rdy = 1'b1;
        step();
        chk("bp_b2_keep", 128'(tk), 128'(8'h0F));
        chk("bp_b2_last", 128'(tl), 128'(1));
        rdy = 1'b0;
        step();
        chk("bp_b2_hold_k", 128'(tk), 128'(8'h0F));
        chk("bp_b2_hold_l", 128'(tl), 128'(1));
        chk("bp_b2_hold_v", 128'(tv), 128'(1));
        rdy = 1'b1;
        step();
        chk("bp_beats", 128'(nbeats), 128'(3));
        chk("bp_bytes", 128'(nbytes), 128'(20));
        chk("bp_done", 128'(done), 128'(1));
        en = 1'b0;
        step();

        // length boundaries
        len = 16'd16; mode = 2'd0; limit = 16'd1; en = 1'b1;
        step();
        chk("l16_seq", 128'(td[31:0]), 128'(3));
        chk("l16_b0_keep", 128'(tk), 128'(8'hFF));
        chk("l16_b0_last", 128'(tl), 128'(0));
        step();
        chk("l16_b1_keep", 128'(tk), 128'(8'hFF));
        chk("l16_b1_last", 128'(tl), 128'(1));
        step();
        en = 1'b0;
        step();
        len = 16'd0; en = 1'b1;
        step();
        chk("l0_keep", 128'(tk), 128'(8'h01));
        chk("l0_last", 128'(tl), 128'(1));
        chk("l0_seq", 128'(td[31:0]), 128'(4));
        step();
        en = 1'b0;
        step();

        len = 16'd1; en2 = 1'b1;
        step();
        chk("w128_valid", 128'(tv2), 128'(1));
        chk("w128_busy", 128'(busy2), 128'(1));
        chk("w128_keep", 128'(tk2), 128'(16'h0001));
        chk("w128_last", 128'(tl2), 128'(1));
        chk("w128_data", td2, 128'h0F0E0D0C_0B0A0908_07060504_00000000);
        en2 = 1'b0;
        step();
        chk("w128_done", 128'(done2), 128'(1));
        step();
        chk("w128_done_clr", 128'(done2), 128'(0));

        // back-to-back single-beat frames
        len = 16'd8; ifg = 8'd0; limit = 16'd0; en = 1'b1;
        step();
        chk("b2b_v0", 128'(tv), 128'(1));
        chk("b2b_seq0", 128'(td[31:0]), 128'(5));
        chk("b2b_last0", 128'(tl), 128'(1));
        step();
        chk("b2b_v1", 128'(tv), 128'(1));
        chk("b2b_seq1", 128'(td[31:0]), 128'(6));
        step();
        chk("b2b_v2", 128'(tv), 128'(1));
        chk("b2b_seq2", 128'(td[31:0]), 128'(7));
        en = 1'b0;
        step();
        chk("b2b_stop_v", 128'(tv), 128'(0));
        chk("b2b_stop_busy", 128'(busy), 128'(0));

        // enable dropped on beat 1 of a 4-beat frame
        len = 16'd32; ifg = 8'd2; en = 1'b1;
        step();
        chk("ed_seq", 128'(td[31:0]), 128'(8));
        step();
        chk("ed_b1", 128'(td), 128'(64'h0F0E0D0C_0B0A0908));
        en = 1'b0;
        step();
        chk("ed_b2_v", 128'(tv), 128'(1));
        chk("ed_b2", 128'(td), 128'(64'h17161514_13121110));
        step();
        chk("ed_b3", 128'(td), 128'(64'h1F1E1D1C_1B1A1918));
        chk("ed_b3_last", 128'(tl), 128'(1));
        chk("ed_b3_keep", 128'(tk), 128'(8'hFF));
        step();
        chk("ed_gap_v", 128'(tv), 128'(0));
        chk("ed_gap_busy", 128'(busy), 128'(1));
        step();
        chk("ed_gap2_busy", 128'(busy), 128'(1));
        step();
        chk("ed_idle_busy", 128'(busy), 128'(0));
        chk("ed_idle_v", 128'(tv), 128'(0));

        // reset on beat 2, then LFSR mode from the seed
        ifg = 8'd0; en = 1'b1;
        step(); step(); step();
        chk("rm_b2", 128'(td), 128'(64'h17161514_13121110));
        rst = 1'b0;
        step();
        chk("rm_valid", 128'(tv), 128'(0));
        chk("rm_busy", 128'(busy), 128'(0));
        rst = 1'b1; mode = 2'd1; len = 16'd16; limit = 16'd1;
        step();
        chk("lf_b0", 128'(td), 128'(64'hFFFFFFFF_00000000));
        step();
        chk("lf_b1", 128'(td), 128'(64'hFFDFFFFC_FFDFFFFC));
        chk("lf_b1_last", 128'(tl), 128'(1));
        step();
        chk("lf_done", 128'(done), 128'(1));
        en = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
